// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: entry layout, access size
// encoding and byte-strobe/alignment helpers.
package store_buffer_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'd0,
        SZ_HALF     = 2'd1,
        SZ_WORD     = 2'd2,
        SZ_WORD_ALT = 2'd3
    } mem_size_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_t;

    function automatic logic [SB_STRB_W-1:0] size_to_strb(input mem_size_t size,
                                                          input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [SB_DATA_W-1:0] strb_to_mask(input logic [SB_STRB_W-1:0] strb);
        logic [SB_DATA_W-1:0] m;
        for (int b = 0; b < SB_STRB_W; b++) m[8*b +: 8] = {8{strb[b]}};
        return m;
    endfunction

    function automatic logic [SB_DATA_W-1:0] align_data(input logic [SB_DATA_W-1:0] d,
                                                        input logic [1:0] off);
        return d << {off, 3'b000};
    endfunction

endpackage

// File: rtl/sb_forward_merge.sv
// Load-forwarding merge over the buffered entries, presented oldest first;
// the newest buffered copy of each byte wins.
module sb_forward_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t             ent [DEPTH],
    input  logic [DEPTH-1:0]      ent_vld,
    input  logic [SB_ADDR_W-1:0]  ld_addr,
    input  logic [1:0]            ld_size,
    output logic                  cover_all,
    output logic                  cover_some,
    output logic [SB_DATA_W-1:0]  ld_data
);

    logic [SB_STRB_W-1:0] req_strb;
    logic [SB_STRB_W-1:0] cov;
    logic [SB_STRB_W-1:0] hit_bytes;
    logic [SB_ADDR_W-1:0] ld_waddr;
    logic [SB_DATA_W-1:0] merged;

    always_comb begin
        req_strb = size_to_strb(mem_size_t'(ld_size), ld_addr[1:0]);
        ld_waddr = {ld_addr[SB_ADDR_W-1:2], 2'b00};
        cov      = '0;
        merged   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_vld[k] && ent[k].addr == ld_waddr) begin
                for (int b = 0; b < SB_STRB_W; b++) begin
                    if (ent[k].strb[b]) begin
                        merged[8*b +: 8] = ent[k].data[8*b +: 8];
                        cov[b]           = 1'b1;
                    end
                end
            end
        end
        hit_bytes  = cov & req_strb;
        ld_data    = merged & strb_to_mask(hit_bytes);
        cover_all  = (hit_bytes == req_strb);
        cover_some = |hit_bytes;
    end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: coalescing byte-strobed FIFO with load forwarding
// and an in-order, one-entry-at-a-time drain to the data memory port.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_valid,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [DATA_W-1:0] enq_data,
    input  logic [1:0]        enq_size,
    output logic              enq_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    output logic              ld_hit,
    output logic              ld_conflict,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic              drain_req,
    output logic              empty,
    output logic              stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t            ent [DEPTH];
    sb_entry_t            ord [DEPTH];
    logic [DEPTH-1:0]     ord_vld;
    logic [PTR_W-1:0]     head, tail, tail_m1;
    logic [CNT_W-1:0]     count;
    sb_state_t            state;

    logic                 full, enq_fire, coal, alloc, pop;
    logic [SB_ADDR_W-1:0] enq_waddr;
    logic [SB_STRB_W-1:0] enq_strb, merged_strb;
    logic [SB_DATA_W-1:0] enq_sdata, enq_bmask, merged_data;
    sb_entry_t            head_ent;
    logic                 fwd_all, fwd_some;
    logic [SB_DATA_W-1:0] fwd_data;

    assign full      = (count == CNT_W'(DEPTH));
    assign enq_ready = !full;
    assign empty     = (count == '0);
    assign enq_fire  = enq_valid && !full;
    assign tail_m1   = tail - PTR_W'(1);

    assign enq_waddr = SB_ADDR_W'({enq_addr[ADDR_W-1:2], 2'b00});
    assign enq_strb  = size_to_strb(mem_size_t'(enq_size), enq_addr[1:0]);
    assign enq_sdata = align_data(SB_DATA_W'(enq_data), enq_addr[1:0]);
    assign enq_bmask = strb_to_mask(enq_strb);

    // The head is frozen once its request is on the bus, so it cannot absorb stores.
    assign coal = enq_fire && (count != '0) && (ent[tail_m1].addr == enq_waddr)
                  && !(state == SB_REQ && tail_m1 == head);
    assign alloc = enq_fire && !coal;
    assign pop   = (state == SB_REQ) && mem_ack;

    assign merged_data = (ent[tail_m1].data & ~enq_bmask) | (enq_sdata & enq_bmask);
    assign merged_strb = ent[tail_m1].strb | enq_strb;

    // A store coalescing into the head on the load edge must reach the output regs too.
    always_comb begin
        head_ent = ent[head];
        if (coal && tail_m1 == head) begin
            head_ent.data = merged_data;
            head_ent.strb = merged_strb;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ord[k]     = ent[head + PTR_W'(k)];
            ord_vld[k] = (CNT_W'(k) < count);
        end
    end

    sb_forward_merge #(.DEPTH(DEPTH)) u_fwd (
        .ent        (ord),
        .ent_vld    (ord_vld),
        .ld_addr    (SB_ADDR_W'(ld_addr)),
        .ld_size    (ld_size),
        .cover_all  (fwd_all),
        .cover_some (fwd_some),
        .ld_data    (fwd_data)
    );

    assign ld_hit      = ld_valid && fwd_all;
    assign ld_conflict = ld_valid && fwd_some && !fwd_all;
    assign ld_data     = DATA_W'(fwd_data);
    assign stall_req   = (enq_valid && full) || (ld_valid && ld_conflict) || (drain_req && !empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= SB_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i].strb <= '0;
        end else begin
            if (coal) begin
                ent[tail_m1].data <= merged_data;
                ent[tail_m1].strb <= merged_strb;
            end else if (alloc) begin
                ent[tail] <= '{addr: enq_waddr, data: enq_sdata, strb: enq_strb};
                tail      <= tail + PTR_W'(1);
            end
            if (pop) head <= head + PTR_W'(1);
            count <= count + CNT_W'(alloc) - CNT_W'(pop);

            case (state)
                SB_IDLE: begin
                    if (count != '0) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= ADDR_W'(head_ent.addr);
                        mem_wdata <= DATA_W'(head_ent.data);
                        mem_wstrb <= head_ent.strb;
                        state     <= SB_REQ;
                    end
                end
                SB_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= SB_IDLE;
                    end
                end
                default: state <= SB_IDLE;
            endcase
        end
    end

endmodule
